// File: rtl/lenet5_img_sequencer_if.sv
// Sequencer <-> lenet5 core link: pixel stream out, request/end/next-image handshakes and class back.
interface lenet5_img_sequencer_if #(
  parameter int I_BW = 8
);
  logic            o_net_ce;
  logic [I_BW-1:0] o_fmap;
  logic            o_fmap_valid;
  logic            i_net_req;
  logic            i_net_end;
  logic            i_net_rst;
  logic [3:0]      i_net_result;

  modport master (
    output o_net_ce, o_fmap, o_fmap_valid,
    input  i_net_req, i_net_end, i_net_rst, i_net_result
  );

  modport slave (
    input  o_net_ce, o_fmap, o_fmap_valid,
    output i_net_req, i_net_end, i_net_rst, i_net_result
  );
endinterface

// File: rtl/lenet5_img_sequencer.sv
// Batch controller: streams image-memory pixels into lenet5 and scores each result against its label.
// Latency: pixel request -> o_mem_rd 1 cycle, -> o_fmap_valid 2 cycles; end -> o_result_valid 1 cycle.
// Backpressure: none; the core paces pixels via i_net_req and images via i_net_end/i_net_rst.
module lenet5_img_sequencer #(
  parameter int I_BW    = 8,
  parameter int IMG_PIX = 784,
  parameter int NUM_IMG = 100,
  parameter int ADDR_W  = 17,
  parameter int IDX_W   = 7
) (
  input  logic              clk,
  input  logic              global_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [I_BW-1:0]   i_mem_data,
  lenet5_img_sequencer_if.master net,
  input  logic [3:0]        i_label,
  output logic [IDX_W-1:0]  o_img_idx,
  output logic              o_result_valid,
  output logic [3:0]        o_result,
  output logic              o_correct,
  output logic [IDX_W:0]    o_correct_cnt,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int PIX_W = $clog2(IMG_PIX + 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMG_PIX - 1);
  localparam logic [PIX_W-1:0] PIX_END  = PIX_W'(IMG_PIX);
  localparam logic [IDX_W:0]   CNT_MAX  = (IDX_W + 1)'(NUM_IMG);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IMG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_WAIT_END,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [PIX_W-1:0]  pix_q;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  img_idx_q;
  logic              mem_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              rd_pend_q;
  logic [I_BW-1:0]   fmap_q;
  logic              fmap_valid_q;
  logic              net_ce_q;
  logic              result_valid_q;
  logic [3:0]        result_q;
  logic              correct_q;
  logic [IDX_W:0]    correct_cnt_q;
  logic              err_q;

  logic match;
  logic last_img;
  logic do_adv;

  assign match    = (net.i_net_result == i_label);
  assign last_img = (img_idx_q == IDX_LAST);
  // A same-cycle end+next in WAIT_END advances exactly like a next-image request in NEXT.
  assign do_adv   = ((state_q == S_WAIT_END) && net.i_net_end && net.i_net_rst) ||
                    ((state_q == S_NEXT) && net.i_net_rst);

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q        <= S_IDLE;
      pix_q          <= '0;
      base_q         <= '0;
      img_idx_q      <= '0;
      mem_rd_q       <= 1'b0;
      mem_addr_q     <= '0;
      rd_pend_q      <= 1'b0;
      fmap_q         <= '0;
      fmap_valid_q   <= 1'b0;
      net_ce_q       <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      correct_q      <= 1'b0;
      correct_cnt_q  <= '0;
      err_q          <= 1'b0;
    end else begin
      mem_rd_q       <= 1'b0;
      result_valid_q <= 1'b0;
      rd_pend_q      <= mem_rd_q;
      fmap_valid_q   <= rd_pend_q;
      if (rd_pend_q) begin
        fmap_q <= i_mem_data;
      end

      if (i_abort) begin
        state_q      <= S_IDLE;
        net_ce_q     <= 1'b0;
        mem_rd_q     <= 1'b0;
        rd_pend_q    <= 1'b0;
        fmap_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (i_start) begin
              img_idx_q     <= '0;
              pix_q         <= '0;
              base_q        <= '0;
              correct_cnt_q <= '0;
              err_q         <= 1'b0;
              net_ce_q      <= 1'b1;
              state_q       <= S_FEED;
            end
          end
          S_FEED: begin
            if (net.i_net_end || net.i_net_rst) begin
              err_q <= 1'b1;
            end
            if (net.i_net_req && (pix_q < PIX_END)) begin
              mem_rd_q   <= 1'b1;
              mem_addr_q <= base_q + ADDR_W'(pix_q);
              pix_q      <= pix_q + PIX_W'(1);
              if (pix_q == PIX_LAST) begin
                state_q <= S_WAIT_END;
              end
            end
          end
          S_WAIT_END: begin
            if (net.i_net_end) begin
              result_q       <= net.i_net_result;
              correct_q      <= match;
              result_valid_q <= 1'b1;
              if (match && (correct_cnt_q != CNT_MAX)) begin
                correct_cnt_q <= correct_cnt_q + (IDX_W + 1)'(1);
              end
              state_q <= S_NEXT;
            end else if (net.i_net_rst) begin
              err_q <= 1'b1;
            end
          end
          S_NEXT: ;
          default: state_q <= S_IDLE;
        endcase

        if (do_adv) begin
          if (last_img) begin
            state_q  <= S_DONE;
            net_ce_q <= 1'b0;
          end else begin
            img_idx_q <= img_idx_q + IDX_W'(1);
            base_q    <= base_q + ADDR_W'(IMG_PIX);
            pix_q     <= '0;
            state_q   <= S_FEED;
          end
        end
      end
    end
  end

  assign o_mem_rd         = mem_rd_q;
  assign o_mem_addr       = mem_addr_q;
  assign net.o_net_ce     = net_ce_q;
  assign net.o_fmap       = fmap_q;
  assign net.o_fmap_valid = fmap_valid_q;
  assign o_img_idx        = img_idx_q;
  assign o_result_valid   = result_valid_q;
  assign o_result         = result_q;
  assign o_correct        = correct_q;
  assign o_correct_cnt    = correct_cnt_q;
  assign o_busy           = (state_q == S_FEED) || (state_q == S_WAIT_END) || (state_q == S_NEXT);
  assign o_done           = (state_q == S_DONE);
  assign o_err            = err_q;

endmodule
